// File: rtl/pipeline_hazard_scoreboard.sv
// pipeline_hazard_scoreboard
// Hazard and forwarding controller for the 5-stage RISC-V pipeline. Keeps a shadow copy of the
// E/M/W destination state and produces stall, flush and E-stage forwarding selects.
// Optional variable-latency execute (MUL/DIV) support is compiled in when HAZARD_MC_EN is defined.
module pipeline_hazard_scoreboard #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validD,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rdD,
    input  logic              regWriteD,
    input  logic              loadD,
    input  logic              mcD,
    input  logic [1:0]        PCSrcE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              mcStartE,
    output logic              mcBusy
);

    // Shadow pipeline state
    logic              validE;
    logic [REG_AW-1:0] rs1E;
    logic [REG_AW-1:0] rs2E;
    logic [REG_AW-1:0] rdE;
    logic              regWriteE;
    logic              loadE;

    logic              validM;
    logic [REG_AW-1:0] rdM;
    logic              regWriteM;

    logic              validW;
    logic [REG_AW-1:0] rdW;
    logic              regWriteW;

    logic              busy;
    logic              loadUse;
    logic              redirect;

    logic              hitM1;
    logic              hitM2;
    logic              hitW1;
    logic              hitW2;

    // x0 never matches, so a write to x0 is never forwarded.
    assign hitM1 = validM && regWriteM && (rdM != '0) && (rdM == rs1E);
    assign hitM2 = validM && regWriteM && (rdM != '0) && (rdM == rs2E);
    assign hitW1 = validW && regWriteW && (rdW != '0) && (rdW == rs1E);
    assign hitW2 = validW && regWriteW && (rdW != '0) && (rdW == rs2E);

    // Operand selects: M result has priority over W result
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (hitM1) begin
            forwardAE = 2'b10;
        end else if (hitW1) begin
            forwardAE = 2'b01;
        end
        if (hitM2) begin
            forwardBE = 2'b10;
        end else if (hitW2) begin
            forwardBE = 2'b01;
        end
    end

    // Load-use and redirect detection; both are suppressed while the multi-cycle unit is busy
    always_comb begin
        loadUse  = 1'b0;
        redirect = 1'b0;
        if (!busy) begin
            loadUse  = validE && loadE && (rdE != '0) && validD &&
                       ((rdE == rs1D) || (rdE == rs2D));
            redirect = validE && (PCSrcE != 2'b00);
        end
        stallF = busy || (loadUse && !redirect);
        stallD = busy || (loadUse && !redirect);
        flushD = redirect;
        flushE = redirect || loadUse;
    end

    // E stage: hold while busy, insert a clean bubble on flush, otherwise take D
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validE    <= 1'b0;
            rs1E      <= '0;
            rs2E      <= '0;
            rdE       <= '0;
            regWriteE <= 1'b0;
            loadE     <= 1'b0;
        end else if (!stallE) begin
            if (flushE) begin
                validE    <= 1'b0;
                rs1E      <= '0;
                rs2E      <= '0;
                rdE       <= '0;
                regWriteE <= 1'b0;
                loadE     <= 1'b0;
            end else begin
                validE    <= validD;
                rs1E      <= rs1D;
                rs2E      <= rs2D;
                rdE       <= rdD;
                regWriteE <= regWriteD;
                loadE     <= loadD;
            end
        end
    end

    // M and W stages: a bubble enters M while E is still occupied
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validM    <= 1'b0;
            rdM       <= '0;
            regWriteM <= 1'b0;
            validW    <= 1'b0;
            rdW       <= '0;
            regWriteW <= 1'b0;
        end else begin
            validM    <= validE && !stallE;
            rdM       <= rdE;
            regWriteM <= regWriteE;
            validW    <= validM;
            rdW       <= rdM;
            regWriteW <= regWriteM;
        end
    end

`ifdef HAZARD_MC_EN
    typedef enum logic {StIdle, StBusy} mcState_t;

    mcState_t          mcState;
    logic [CNT_W-1:0]  mcCnt;
    logic              mcStartQ;
    logic              mcEnter;

    // A multi-cycle instruction actually moves from D into E on this edge
    assign mcEnter = validD && mcD && !stallE && !flushE;

    // Multi-cycle occupancy FSM; the counter holds the remaining extra E cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcState  <= StIdle;
            mcCnt    <= '0;
            mcStartQ <= 1'b0;
        end else begin
            mcStartQ <= mcEnter;
            unique case (mcState)
                StIdle: begin
                    if (mcEnter && (MC_LAT > 1)) begin
                        mcState <= StBusy;
                        mcCnt   <= CNT_W'(MC_LAT - 1);
                    end
                end
                StBusy: begin
                    if (mcCnt == CNT_W'(1)) begin
                        mcState <= StIdle;
                        mcCnt   <= '0;
                    end else begin
                        mcCnt <= mcCnt - CNT_W'(1);
                    end
                end
                default: begin
                    mcState <= StIdle;
                    mcCnt   <= '0;
                end
            endcase
        end
    end

    assign mcBusy   = (mcState == StBusy);
    assign mcStartE = mcStartQ;
    assign stallE   = mcBusy;
    assign busy     = mcBusy;
`else
    // Every instruction spends one cycle in E; the multi-cycle flag is not consulted.
    logic unusedMcD;
    localparam int unsigned unusedCfg = MC_LAT + CNT_W;

    assign unusedMcD = mcD;
    assign mcBusy    = 1'b0;
    assign mcStartE  = 1'b0;
    assign stallE    = 1'b0;
    assign busy      = 1'b0;
`endif

endmodule

// File: doc/pipeline_hazard_scoreboard.md
# pipeline_hazard_scoreboard

Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline. It keeps its own shadow copy of the E/M/W destination-register state and generates stall, flush and forwarding selects. It also supports a variable-latency execute unit (MUL/DIV) that holds the E stage for a configurable number of cycles. It sits beside the datapath and drives the IF/ID, ID/EX and EX/MEM register enables and clears, plus the E-stage operand muxes.

## Interface
- REG_AW, 5: register-address width; register 0 is hard-wired zero and never matches.
- MC_LAT, 4: cycles a multi-cycle instruction occupies E (≥1).
- CNT_W, 3: width of the multi-cycle down-counter; must satisfy 2^CNT_W > MC_LAT.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- validD  in  1  D holds a real instruction.
- rs1D, rs2D, rdD  in  REG_AW each  D-stage source and destination registers.
- regWriteD  in  1  D instruction writes rdD.
- loadD  in  1  D instruction is a load.
- mcD  in  1  D instruction is multi-cycle.
- PCSrcE  in  2  branch-controller select; nonzero means redirect.
- stallF, stallD  out  1  hold the PC register and IF/ID.
- stallE  out  1  hold ID/EX (multi-cycle busy).
- flushD, flushE  out  1  clear IF/ID and ID/EX.
- forwardAE, forwardBE  out  2  operand select: 00 register file, 01 W result, 10 M result.
- mcStartE  out  1  one-cycle pulse when a multi-cycle instruction enters E; the datapath captures its operands here.
- mcBusy  out  1  multi-cycle unit occupied.

## Operation
- Shadow state per stage E/M/W: valid, rd, regWrite; E additionally holds rs1, rs2, load, mc. mcCnt is CNT_W bits.
- Forwarding, for each operand of E (rs1E→forwardAE, rs2E→forwardBE):
  - 10 if validM, regWriteM, rdM≠0 and rdM==rsE.
  - Otherwise 01 if the same conditions hold for W.
  - Otherwise 00. M has priority over W.
- Load-use condition: validE, loadE, rdE≠0, and rdE equals rs1D or rs2D with validD. Response: stallF=stallD=1 and flushE=1 for one cycle.
- Redirect condition: validE and PCSrcE≠0 and not mcBusy. Response: flushD=flushE=1.
  - Redirect has priority over load-use; stallF/stallD are 0 that cycle.
- Multi-cycle states, IDLE and BUSY:
  - IDLE→BUSY when an mc instruction enters E and MC_LAT>1: mcCnt←MC_LAT−1, mcStartE=1 in its first E cycle.
  - BUSY: stallF=stallD=stallE=1, mcBusy=1, mcCnt decrements each cycle, a bubble is inserted into M.
  - BUSY→IDLE when mcCnt reaches 1 on a clock edge; the instruction advances to M on the next edge.
  - MC_LAT=1: mcStartE still pulses, no BUSY state.
- Shadow update per edge:
  - E←D inputs, unless stallE (hold) or flushE (E.valid←0).
  - M←E, unless E is busy (M.valid←0).
  - W←M unconditionally.
- Load-use and redirect are evaluated only when not mcBusy. While BUSY, a load-use match against D is resolved after E drains.

## Timing
- Forwarding, stall and flush outputs are combinational from shadow state and D inputs; zero-cycle latency to the datapath in the same cycle.
- State updates one edge after inputs.
- Load-use costs exactly 1 bubble. Redirect costs 2 squashed slots. A multi-cycle op costs MC_LAT−1 stall cycles.
- Reset (rst=0), asynchronous:
  - All valid bits 0, mcCnt=0, state IDLE.
  - Every output forced to 0 regardless of inputs, including forwardAE=forwardBE=00.
- Reset asserted mid-BUSY aborts the operation; after release the pipeline resumes empty with no stall.
- A back-to-back mc instruction in D while BUSY waits in D, then enters E and restarts the counter with a fresh mcStartE pulse.

## Configuration
- HAZARD_MC_EN defined: multi-cycle logic and the mcCnt counter are compiled in, with behaviour as above.
- HAZARD_MC_EN undefined:
  - mcD is ignored and the counter is removed.
  - stallE, mcBusy and mcStartE are tied to 0.
  - Every instruction spends 1 cycle in E.

## Test plan
- Forward priority: x5 written in both M and W, rs1E=5 → forwardAE=10; after M drains, W only → forwardAE=01; rdM=0 → forwardAE=00.
- Load-use: lw x7 in E with rs2D=7 → one cycle with stallF=stallD=flushE=1, then forwardBE=01 when the dependent instruction reaches E.
- Redirect versus load-use in the same cycle: PCSrcE=01 with load-use true → flushD=flushE=1, stallF=stallD=0.
- Multi-cycle, MC_LAT=4 (with HAZARD_MC_EN): mcStartE high for 1 cycle, stallE high for 3 cycles, M.valid=0 for those 3 edges, then the instruction reaches M.
- Reset mid-BUSY: drop rst at BUSY cycle 2 → all outputs 0 immediately; release → mcBusy=0 and no stall on an empty pipeline.
- HAZARD_MC_EN undefined: mcD=1 → stallE=0 and the instruction reaches M one edge after entering E.
